// File: rtl/debug_controller.sv
// Byte-oriented debug controller: reads probe words out over a byte stream,
// single-steps or free-runs the CPU through a registered clock enable, and
// halts on command. Optional PC breakpoint support is compiled in only when
// the macro DEBUG_BREAKPOINT_EN is defined; the default build omits it.
module debug_controller #(
  parameter int NUM_PROBES = 32,
  parameter int PROBE_W    = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cmd_valid,
  input  logic [7:0]                    cmd_data,
  output logic                          cmd_ready,
  input  logic [NUM_PROBES*PROBE_W-1:0] probe_bus,
  input  logic [31:0]                   pc,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          cpu_en,
  output logic                          running
);

  localparam int BYTES = PROBE_W / 8;

  typedef enum logic [2:0] {IDLE, SEND, STEP, RUN, BPLOAD} state_t;

  state_t             state;
  logic [PROBE_W-1:0] shift_reg;
  logic [PROBE_W-1:0] shift_next;
  logic [PROBE_W-1:0] probe_sel;
  logic [3:0]         byte_cnt;
  logic [1:0]         opcode;
  logic [5:0]         arg;
  logic               accept;
  logic               halt_cmd;
  logic               bp_hit;
  logic               bp_last;
  logic               bp_allowed;

  assign opcode     = cmd_data[7:6];
  assign arg        = cmd_data[5:0];
  assign cmd_ready  = (state == IDLE) || (state == RUN) || (state == BPLOAD);
  assign accept     = cmd_valid && cmd_ready;
  assign halt_cmd   = accept && (cmd_data == 8'hC0);
  assign shift_next = shift_reg >> 8;

  // Probe word selection; an argument past the last probe reads as zero.
  always_comb begin
    probe_sel = '0;
    for (int i = 0; i < NUM_PROBES; i++) begin
      if (arg == 6'(i)) probe_sel = probe_bus[i*PROBE_W +: PROBE_W];
    end
  end

`ifdef DEBUG_BREAKPOINT_EN
  logic [31:0] bp_addr;
  logic        bp_armed;
  logic [1:0]  bp_cnt;

  assign bp_allowed = 1'b1;
  assign bp_hit     = bp_armed && (pc == bp_addr);
  assign bp_last    = (bp_cnt == 2'd3);

  // Breakpoint address register: disarmed while a new address is loading,
  // armed once the fourth byte lands.
  always_ff @(posedge clock) begin
    if (reset) begin
      bp_addr  <= '0;
      bp_armed <= 1'b0;
      bp_cnt   <= '0;
    end else if (state == IDLE && accept && cmd_data == 8'hC1) begin
      bp_armed <= 1'b0;
      bp_cnt   <= '0;
    end else if (state == BPLOAD && accept) begin
      bp_addr[{bp_cnt, 3'b000} +: 8] <= cmd_data;
      bp_cnt <= bp_cnt + 2'd1;
      if (bp_last) bp_armed <= 1'b1;
    end
  end
`else
  logic unused_pc;

  assign bp_allowed = 1'b0;
  assign bp_hit     = 1'b0;
  assign bp_last    = 1'b0;
  assign unused_pc  = ^pc;
`endif

  // Main control FSM; every output it drives is registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cpu_en    <= 1'b0;
      running   <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      shift_reg <= '0;
      byte_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (opcode)
              2'b00: begin
                shift_reg <= probe_sel;
                tx_data   <= probe_sel[7:0];
                tx_valid  <= 1'b1;
                byte_cnt  <= '0;
                state     <= SEND;
              end
              2'b01: begin
                cpu_en <= 1'b1;
                state  <= STEP;
              end
              2'b10: begin
                cpu_en  <= 1'b1;
                running <= 1'b1;
                state   <= RUN;
              end
              default: begin
                // HALT while idle and unknown system args fall through here.
                if (bp_allowed && arg == 6'h01) state <= BPLOAD;
              end
            endcase
          end
        end
        SEND: begin
          // tx_valid is always high in SEND, so tx_ready alone completes a byte.
          if (tx_ready) begin
            if (byte_cnt == 4'(BYTES - 1)) begin
              tx_valid  <= 1'b0;
              tx_data   <= 8'h00;
              shift_reg <= '0;
              byte_cnt  <= '0;
              state     <= IDLE;
            end else begin
              shift_reg <= shift_next;
              tx_data   <= shift_next[7:0];
              byte_cnt  <= byte_cnt + 4'd1;
            end
          end
        end
        STEP: begin
          cpu_en <= 1'b0;
          state  <= IDLE;
        end
        RUN: begin
          // HALT wins over a simultaneous breakpoint hit; everything else is dropped.
          if (halt_cmd) begin
            cpu_en  <= 1'b0;
            running <= 1'b0;
            state   <= IDLE;
          end else if (bp_hit) begin
            cpu_en    <= 1'b0;
            running   <= 1'b0;
            shift_reg <= PROBE_W'(8'hBB);
            tx_data   <= 8'hBB;
            tx_valid  <= 1'b1;
            byte_cnt  <= 4'(BYTES - 1);
            state     <= SEND;
          end
        end
        BPLOAD: begin
          if (accept && bp_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_controller.sv
// Directed bench for debug_controller: expected tx bytes are queued when a
// command is issued and compared as each byte is handed to the sink.
module tb_debug_controller;

  localparam int NUM_PROBES = 32;
  localparam int PROBE_W    = 32;

  logic                          clock = 1'b0;
  logic                          reset;
  logic                          cmd_valid;
  logic [7:0]                    cmd_data;
  logic                          cmd_ready;
  logic [NUM_PROBES*PROBE_W-1:0] probe_bus;
  logic [31:0]                   pc;
  logic [7:0]                    tx_data;
  logic                          tx_valid;
  logic                          tx_ready;
  logic                          cpu_en;
  logic                          running;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  debug_controller #(.NUM_PROBES(NUM_PROBES), .PROBE_W(PROBE_W)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .probe_bus(probe_bus), .pc(pc), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .cpu_en(cpu_en), .running(running)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Score any byte handed over at the coming edge, then advance one clock.
  task automatic cycle();
    logic [7:0] exp;
    if (tx_valid && tx_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL tx_unexpected observed=%0h expected=none", tx_data);
      end
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        checks++;
        assert (tx_data === exp) else begin
          errors++;
          $error("FAIL tx_byte observed=%0h expected=%0h", tx_data, exp);
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_data  = b;
    check("cmd_ready_on_send", 32'(cmd_ready), 32'd1);
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cycle();
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[i*8 +: 8]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    pc        = 32'h0;
    tx_ready  = 1'b0;
    for (int i = 0; i < NUM_PROBES; i++)
      probe_bus[i*PROBE_W +: PROBE_W] = {8'(i + 1), 24'hA5C35A};
    probe_bus[3*PROBE_W +: PROBE_W]  = 32'hDEADBEEF;
    probe_bus[5*PROBE_W +: PROBE_W]  = 32'h01234567;
    probe_bus[31*PROBE_W +: PROBE_W] = 32'h96F0C3A5;
    cycle();
    cycle();
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_running", 32'(running), 32'd0);
    reset = 1'b0;
    cycle();
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // READ probe 3: four bytes on consecutive cycles, LSB first.
    tx_ready = 1'b1;
    push_word(32'hDEADBEEF);
    send_cmd(8'h03);
    for (int k = 0; k < 4; k++) begin
      check("read_consec_valid", 32'(tx_valid), 32'd1);
      check("read_cmd_ready_low", 32'(cmd_ready), 32'd0);
      cycle();
    end
    check("read_done_valid", 32'(tx_valid), 32'd0);
    check("read_done_ready", 32'(cmd_ready), 32'd1);
    check("read_queue", 32'(exp_q.size()), 32'd0);

    // Backpressure: first byte held five cycles.
    tx_ready = 1'b0;
    push_word(32'hDEADBEEF);
    send_cmd(8'h03);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 32'(tx_valid), 32'd1);
      check("stall_data", 32'(tx_data), 32'hEF);
      cycle();
    end
    tx_ready = 1'b1;
    drain(10);
    check("stall_done_valid", 32'(tx_valid), 32'd0);

    // Other probes, including the last one.
    push_word(32'h01234567);
    send_cmd(8'h05);
    drain(10);
    push_word(32'h96F0C3A5);
    send_cmd(8'h1F);
    drain(10);

    // STEP: exactly one enabled cycle.
    send_cmd(8'h40);
    check("step_cpu_en", 32'(cpu_en), 32'd1);
    check("step_cmd_ready", 32'(cmd_ready), 32'd0);
    cycle();
    check("step_cpu_en_off", 32'(cpu_en), 32'd0);
    check("step_ready_back", 32'(cmd_ready), 32'd1);
    cycle();
    check("step_cpu_en_stays", 32'(cpu_en), 32'd0);

    // RUN for ten cycles with discarded commands, then HALT.
    hi = 0;
    send_cmd(8'h80);
    if (cpu_en) hi++;
    check("run_running", 32'(running), 32'd1);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin cmd_valid = 1'b1; cmd_data = 8'h03; end
      if (k == 6) begin cmd_valid = 1'b1; cmd_data = 8'h40; end
      cycle();
      cmd_valid = 1'b0;
      if (cpu_en) hi++;
    end
    check("run_still_running", 32'(running), 32'd1);
    send_cmd(8'hC0);
    if (cpu_en) hi++;
    check("run_cpu_en_cycles", 32'(hi), 32'd11);
    check("halt_cpu_en", 32'(cpu_en), 32'd0);
    check("halt_running", 32'(running), 32'd0);
    check("halt_cmd_ready", 32'(cmd_ready), 32'd1);
    cycle();
    cycle();
    check("run_no_tx", 32'(tx_valid), 32'd0);

    // HALT while idle and an unknown system arg: no effect.
    send_cmd(8'hC0);
    check("idle_halt_cpu_en", 32'(cpu_en), 32'd0);
    check("idle_halt_ready", 32'(cmd_ready), 32'd1);
    send_cmd(8'hC5);
    check("noop_ready", 32'(cmd_ready), 32'd1);
    check("noop_tx", 32'(tx_valid), 32'd0);

    // Out-of-range probe reads zero; reset lands after the second byte.
    push_word(32'h0);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    send_cmd(8'h3F);
    cycle();
    cycle();
    tx_ready = 1'b0;
    check("oor_third_valid", 32'(tx_valid), 32'd1);
    check("oor_third_data", 32'(tx_data), 32'h00);
    check("oor_queue", 32'(exp_q.size()), 32'd0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("abort_tx_valid", 32'(tx_valid), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort_tx_data", 32'(tx_data), 32'h00);
    tx_ready = 1'b1;
    cycle();
    cycle();
    check("abort_no_reissue", 32'(tx_valid), 32'd0);

`ifdef DEBUG_BREAKPOINT_EN
    // Load breakpoint 0x00000100, run into it.
    send_cmd(8'hC1);
    send_cmd(8'h00);
    send_cmd(8'h01);
    send_cmd(8'h00);
    send_cmd(8'h00);
    check("bp_load_idle_tx", 32'(tx_valid), 32'd0);
    send_cmd(8'h80);
    cycle();
    cycle();
    check("bp_running", 32'(cpu_en), 32'd1);
    pc = 32'h100;
    exp_q.push_back(8'hBB);
    tx_ready = 1'b0;
    cycle();
    pc = 32'h0;
    check("bp_cpu_en_off", 32'(cpu_en), 32'd0);
    check("bp_running_off", 32'(running), 32'd0);
    check("bp_tx_valid", 32'(tx_valid), 32'd1);
    tx_ready = 1'b1;
    drain(5);
    check("bp_done_valid", 32'(tx_valid), 32'd0);
    // HALT together with a hit: halt wins, no notification byte.
    send_cmd(8'h80);
    pc = 32'h100;
    send_cmd(8'hC0);
    pc = 32'h0;
    check("bp_prio_cpu_en", 32'(cpu_en), 32'd0);
    check("bp_prio_tx", 32'(tx_valid), 32'd0);
    cycle();
    cycle();
`else
    // Without breakpoint support 0xC1 does nothing and RUN ignores pc.
    send_cmd(8'hC1);
    check("nobp_ready", 32'(cmd_ready), 32'd1);
    send_cmd(8'h80);
    pc = 32'h100;
    for (int k = 0; k < 5; k++) cycle();
    check("nobp_cpu_en", 32'(cpu_en), 32'd1);
    check("nobp_tx", 32'(tx_valid), 32'd0);
    send_cmd(8'hC0);
    pc = 32'h0;
    check("nobp_halt", 32'(cpu_en), 32'd0);
    cycle();
`endif

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_controller.md
DEBUG_CONTROLLER -- requirements
Module: debug_controller

Interface
REQ-001 SHALL have parameter NUM_PROBES, default 32, number of probe words selectable (1..64).
REQ-002 SHALL have parameter PROBE_W, default 32, probe word width in bits (multiple of 8, 8..64); BYTES = PROBE_W/8.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command byte present.
REQ-006 SHALL have port cmd_data  input  8  command byte: [7:6] opcode, [5:0] argument.
REQ-007 SHALL have port cmd_ready  output  1  command byte accepted when cmd_valid && cmd_ready.
REQ-008 SHALL have port probe_bus  input  NUM_PROBES*PROBE_W  packed probe words; probe i = bits [i*PROBE_W +: PROBE_W].
REQ-009 SHALL have port pc  input  32  current CPU fetch address.
REQ-010 SHALL have port tx_data  output  8  outgoing response byte.
REQ-011 SHALL have port tx_valid  output  1  tx_data valid.
REQ-012 SHALL have port tx_ready  input  1  sink accepts byte when tx_valid && tx_ready.
REQ-013 SHALL have port cpu_en  output  1  registered CPU clock enable (replaces gated debug clock).
REQ-014 SHALL have port running  output  1  high while in RUN state.

Function
REQ-015 SHALL implement states IDLE, SEND, STEP, RUN, BPLOAD; cmd_ready = 1 in IDLE, RUN, BPLOAD, 0 in SEND and STEP.
REQ-016 SHALL decode opcode 00 (READ): snapshot probe[arg] into shift register on acceptance cycle, go to SEND; arg >= NUM_PROBES snapshots 0.
REQ-017 SHALL in SEND present BYTES bytes LSB first, tx_valid asserted from cycle after acceptance, advancing only on tx_valid && tx_ready; tx_data stable while stalled; return to IDLE after last byte transfers.
REQ-018 SHALL decode opcode 01 (STEP): cpu_en high for exactly one cycle (cycle after acceptance), then IDLE.
REQ-019 SHALL decode opcode 10 (RUN): cpu_en high every cycle from cycle after acceptance until halt.
REQ-020 SHALL decode opcode 11 arg 0x00 (HALT): in RUN, cpu_en low from next cycle, state IDLE; in IDLE, no effect.
REQ-021 SHALL in RUN accept and discard every command other than HALT.
REQ-022 SHALL treat opcode 11 with any arg other than 0x00/0x01 as no-op.
REQ-023 SHALL give HALT priority over a breakpoint hit in the same cycle (no notification byte sent).

Reset
REQ-024 SHALL on reset: state IDLE, cpu_en 0, tx_valid 0, tx_data 0x00, running 0, shift register and byte counter 0, breakpoint disarmed.
REQ-025 SHALL abort any SEND, STEP, RUN or BPLOAD when reset asserts mid-operation; no partial byte is reissued afterwards.
REQ-026 SHALL present cmd_ready = 1 on first cycle after reset deasserts.

Configuration
REQ-027 SHALL compile breakpoint logic only when macro DEBUG_BREAKPOINT_EN is defined.
REQ-028 SHALL with DEBUG_BREAKPOINT_EN: opcode 11 arg 0x01 enters BPLOAD, next 4 accepted bytes load bp_addr LSB first and arm it, then IDLE.
REQ-029 SHALL with DEBUG_BREAKPOINT_EN: in RUN, armed and pc == bp_addr -> cpu_en 0 next cycle, state SEND with single byte 0xBB, breakpoint stays armed.
REQ-030 SHALL without DEBUG_BREAKPOINT_EN: opcode 11 arg 0x01 is a no-op, RUN ends only by HALT or reset, no 0xBB ever emitted.

Verification
REQ-031 SHALL cover READ: probe[3]=0xDEADBEEF, cmd 0x03, tx_ready=1 -> bytes EF,BE,AD,DE on 4 consecutive cycles, then IDLE.
REQ-032 SHALL cover backpressure: cmd 0x03, tx_ready low 5 cycles after first byte -> 0xEF held stable, sequence completes unchanged.
REQ-033 SHALL cover STEP then RUN/HALT: cmd 0x40 -> cpu_en pulse of 1 cycle; cmd 0x80, 10 cycles, cmd 0xC0 -> cpu_en high 10+1 cycles, then 0.
REQ-034 SHALL cover breakpoint (macro on): 0xC1,00,01,00,00 then 0x80, pc reaches 0x00000100 -> cpu_en 0 next cycle, tx byte 0xBB.
REQ-035 SHALL cover out-of-range and reset: NUM_PROBES=32, cmd 0x3F -> 4 bytes 0x00; reset after 2nd byte -> tx_valid 0, cmd_ready 1 next cycle.
